// File: rtl/fpa_pkg.sv
// Shared constants and FSM encoding for the FP32 adder round-robin scheduler.
package fpa_pkg;

  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Subtraction is addition of the sign-flipped operand.
  function automatic logic [FP_W-1:0] fp_negate(input logic [FP_W-1:0] v);
    return {~v[SIGN_BIT], v[SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/fpa_rr_arbiter.sv
// Combinational rotating-priority pick: the first valid requester after last_grant wins.
module fpa_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    // Offsets 1..NUM_REQ visit last_grant itself last, so it has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/fpa_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational FP32 adder among NUM_REQ requesters.
// Optional feature: define FPA_SCHED_SUB_EN to add per-requester req_op (1 = X-Y).
module fpa_rr_scheduler
  import fpa_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_x,
  input  logic [NUM_REQ*FP_W-1:0] req_y,
`ifdef FPA_SCHED_SUB_EN
  input  logic [NUM_REQ-1:0]      req_op,
`endif
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FP_W-1:0]         rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy,
  output logic [FP_W-1:0]         fpa_x,
  output logic [FP_W-1:0]         fpa_y,
  input  logic [FP_W-1:0]         fpa_result
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  logic [FP_W-1:0]    sel_x, sel_y;
  logic [FP_W-1:0]    x_arr [NUM_REQ];
  logic [FP_W-1:0]    y_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign x_arr[g] = req_x[FP_W*g +: FP_W];
    assign y_arr[g] = req_y[FP_W*g +: FP_W];
  end

  fpa_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arbiter (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant_oh   (grant_oh),
    .grant_idx  (grant_idx)
  );

  assign sel_x = x_arr[grant_idx];
`ifdef FPA_SCHED_SUB_EN
  assign sel_y = req_op[grant_idx] ? fp_negate(y_arr[grant_idx]) : y_arr[grant_idx];
`else
  assign sel_y = y_arr[grant_idx];
`endif

  assign accept = (state_q == IDLE) && (|req_valid);
  assign busy   = (state_q != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant_oh;
        if (|req_valid) state_d = CALC;
      end
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values in parallel.
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= '0;
      fpa_x        <= '0;
      fpa_y        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fpa_x        <= sel_x;
        fpa_y        <= sel_y;
        rsp_id       <= grant_idx;
        last_grant_q <= grant_idx;
      end
      if (state_q == CALC) begin
        rsp_data  <= fpa_result;
        rsp_valid <= 1'b1;
      end
      // rsp_valid is always high in RESP, so rsp_ready alone completes the handshake.
      if (state_q == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpa_rr_scheduler.sv
// Self-checking bench for fpa_rr_scheduler: directed scenarios plus a randomized transaction model.
// Build with FPA_SCHED_SUB_EN defined to exercise the subtract option.
module tb_fpa_rr_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_x;
  logic [N*32-1:0] req_y;
  logic [N-1:0]    req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic [1:0]      rsp_id;
  logic            busy;
  logic [31:0]     fpa_x;
  logic [31:0]     fpa_y;
  logic [31:0]     fpa_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpa_rr_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
`ifdef FPA_SCHED_SUB_EN
    .req_op     (req_op),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .fpa_x      (fpa_x),
    .fpa_y      (fpa_y),
    .fpa_result (fpa_result)
  );

  // Behavioural FP32 adder for normal numbers (truncating); exact for the small integers used here.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [24:0] mb, ms, m;
    logic [7:0]  e, d;
    if (a[30:0] < b[30:0]) begin big = b; sml = a; end
    else begin big = a; sml = b; end
    if (sml[30:0] == 31'd0) return big;
    d  = big[30:23] - sml[30:23];
    mb = {2'b01, big[22:0]};
    ms = {2'b01, sml[22:0]} >> d;
    m  = (big[31] == sml[31]) ? mb + ms : mb - ms;
    if (m == 25'd0) return 32'd0;
    e = big[30:23];
    if (m[24]) begin
      m = m >> 1;
      e = e + 8'd1;
    end else begin
      for (int k = 0; k < 24 && !m[23]; k++) begin
        m = m << 1;
        e = e - 8'd1;
      end
    end
    return {big[31], e, m[22:0]};
  endfunction

  assign fpa_result = fp_add(fpa_x, fpa_y);

  function automatic logic [31:0] int_to_fp(input int v);
    logic [31:0] m;
    int          p;
    logic        s;
    s = (v < 0);
    m = s ? 32'(-v) : 32'(v);
    if (m == 32'd0) return 32'd0;
    p = 0;
    for (int b = 0; b < 32; b++) if (m[b]) p = b;
    m = (m << (23 - p)) & 32'h007F_FFFF;
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [31:0] x, input logic [31:0] y);
    req_x[32*i +: 32] = x;
    req_y[32*i +: 32] = y;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Grants expected under a fixed request mask, from a fresh reset (pointer at N-1).
  task automatic run_rr(input logic [N-1:0] mask, input int n);
    int ptr, nxt;
    ptr = N - 1;
    for (int i = 0; i < N; i++) set_slot(i, int_to_fp(i + 1), int_to_fp(1));
    req_valid = mask;
    rsp_ready = 1'b1;
    for (int g = 0; g < n; g++) begin
      nxt = -1;
      for (int k = 1; k <= N; k++) if (nxt < 0 && mask[(ptr + k) % N]) nxt = (ptr + k) % N;
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << nxt));
      tick();
      check("rr_calc_ready", 32'(req_ready), 32'd0);
      check("rr_calc_busy", 32'(busy), 32'd1);
      tick();
      check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rr_rsp_id", 32'(rsp_id), 32'(nxt));
      check("rr_rsp_data", rsp_data, int_to_fp(nxt + 2));
      tick();
      ptr = nxt;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  bit          pend [N];
  int          opa [N], opb [N];
  bit          opsub [N];
  bit          outstanding;
  int          acc_cyc, mptr, win, exp_id;
  logic [31:0] exp_data;
  logic [N-1:0] exp_rdy;
  bit          exp_rv;

  initial begin
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_op = '0; rsp_ready = 1'b0;

    // Reset state
    do_reset();
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fpa_x", fpa_x, 32'd0);
    check("rst_fpa_y", fpa_y, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // 1) 1.0 + 1.0 on requester 0, latency 2
    set_slot(0, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 4'b0001;
    #1;
    check("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #1;
    check("t1_calc_busy", 32'(busy), 32'd1);
    check("t1_calc_valid", 32'(rsp_valid), 32'd0);
    check("t1_fpa_x", fpa_x, 32'h3F80_0000);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data", rsp_data, 32'h4000_0000);
    check("t1_rsp_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t1_done_valid", 32'(rsp_valid), 32'd0);
    check("t1_done_busy", 32'(busy), 32'd0);

    // 2) all requesters valid, 3) requesters 0 and 2 only
    do_reset();
    run_rr(4'b1111, 5);
    do_reset();
    run_rr(4'b0101, 4);

    // 4) response back-pressure; pointer is now 2, so requester 1 wins next
    set_slot(1, int_to_fp(5), int_to_fp(2));
    req_valid = 4'b0010;
    #1;
    check("t4_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1111;
    #1;
    check("t4_calc_ready", 32'(req_ready), 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_data", rsp_data, int_to_fp(7));
      check("t4_hold_id", 32'(rsp_id), 32'd1);
      check("t4_hold_ready", 32'(req_ready), 32'd0);
      check("t4_hold_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("t4_hs_ready", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    check("t4_idle_valid", 32'(rsp_valid), 32'd0);
    check("t4_next_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    tick();
    check("t4_next_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 5) reset during CALC restores pointer so requester 0 wins
    req_valid = 4'b0010;
    #1;
    check("t5_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rsp_data", rsp_data, 32'd0);
    check("t5_fpa_x", fpa_x, 32'd0);
    req_valid = 4'b1111;
    #1;
    check("t5_first_win", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    check("t5_rsp_id", 32'(rsp_id), 32'd0);
    check("t5_rsp_valid2", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

`ifdef FPA_SCHED_SUB_EN
    // 6) 3.0 - 1.0 on requester 1
    set_slot(1, 32'h4040_0000, 32'h3F80_0000);
    req_op    = 4'b0010;
    req_valid = 4'b0010;
    #1;
    check("t6_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    req_op    = '0;
    check("t6_fpa_y", fpa_y, 32'hBF80_0000);
    tick();
    check("t6_rsp_data", rsp_data, 32'h4000_0000);
    check("t6_rsp_id", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    // Randomized traffic against a transaction-level model
    do_reset();
    outstanding = 1'b0; acc_cyc = 0; mptr = N - 1; exp_id = 0; exp_data = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          opa[i]   = int'($urandom_range(0, 255));
          opb[i]   = int'($urandom_range(0, 255));
`ifdef FPA_SCHED_SUB_EN
          opsub[i] = 1'($urandom_range(0, 1));
`else
          opsub[i] = 1'b0;
`endif
        end
        req_valid[i] = pend[i];
        req_op[i]    = pend[i] && opsub[i];
        set_slot(i, pend[i] ? int_to_fp(opa[i]) : 32'd0, pend[i] ? int_to_fp(opb[i]) : 32'd0);
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      win = -1;
      if (!outstanding)
        for (int k = 1; k <= N; k++) if (win < 0 && pend[(mptr + k) % N]) win = (mptr + k) % N;
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      exp_rv = outstanding && (cyc >= acc_cyc + 2);
      check("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check("rnd_busy", 32'(busy), 32'(outstanding));
      if (exp_rv) begin
        check("rnd_rsp_data", rsp_data, exp_data);
        check("rnd_rsp_id", 32'(rsp_id), 32'(exp_id));
        if (rsp_ready) outstanding = 1'b0;
      end
      if (win >= 0) begin
        outstanding = 1'b1;
        acc_cyc     = cyc;
        mptr        = win;
        exp_id      = win;
        exp_data    = int_to_fp(opsub[win] ? opa[win] - opb[win] : opa[win] + opb[win]);
        pend[win]   = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
